// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED controller: mode values, button bit order and
// the press-priority resolver.
package led_ctrl_pkg;

    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned BTN_UP  = 0;
    localparam int unsigned BTN_DWN = 1;
    localparam int unsigned BTN_LFT = 2;
    localparam int unsigned BTN_RT  = 3;
    localparam int unsigned BTN_CTR = 4;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ACT_NONE = 3'd0,
        ACT_UP   = 3'd1,
        ACT_DWN  = 3'd2,
        ACT_LFT  = 3'd3,
        ACT_RT   = 3'd4,
        ACT_CTR  = 3'd5
    } action_e;

    // Same-cycle presses resolve up > dwn > lft > rt > ctr; the rest are dropped.
    function automatic action_e press_action(input logic [NUM_BTN-1:0] press);
        action_e act;
        act = ACT_NONE;
        if (press[BTN_UP])       act = ACT_UP;
        else if (press[BTN_DWN]) act = ACT_DWN;
        else if (press[BTN_LFT]) act = ACT_LFT;
        else if (press[BTN_RT])  act = ACT_RT;
        else if (press[BTN_CTR]) act = ACT_CTR;
        return act;
    endfunction

endpackage

// File: rtl/led_ctrl_fsm_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stable-count debounce and
// a one-cycle press pulse on an accepted 0->1 change of the debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done_c;

    assign cnt_done_c = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Pulse is registered alongside db so the action lands one edge after db rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt_done_c) begin
                db    <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_ctrl_fsm.sv
// Board bring-up LED controller: five debounced buttons select static patterns,
// a switch load, or timed left/right rotation of the LED bank.
module led_ctrl_fsm
    import led_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SHIFT_DIV       = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   switches,
    input  logic               btn_up,
    input  logic               btn_dwn,
    input  logic               btn_lft,
    input  logic               btn_rt,
    input  logic               btn_ctr,
    output logic [WIDTH-1:0]   leds,
    output logic [1:0]         mode,
    output logic [NUM_BTN-1:0] btn_db
);

    localparam int unsigned TICK_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;

    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] press;

    mode_e              state;
    mode_e              state_nxt;
    logic [WIDTH-1:0]   leds_nxt;
    logic [TICK_W-1:0]  tick;
    logic [TICK_W-1:0]  tick_nxt;
    logic               wrap_c;
    action_e            act_c;

    assign raw_btn = {btn_ctr, btn_rt, btn_lft, btn_dwn, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw_btn[i]),
            .db   (btn_db[i]),
            .press(press[i])
        );
    end

    assign act_c  = press_action(press);
    assign wrap_c = (state != MODE_STATIC) && (tick == TICK_W'(SHIFT_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_STATIC;
            leds  <= '0;
            tick  <= '0;
        end else begin
            state <= state_nxt;
            leds  <= leds_nxt;
            tick  <= tick_nxt;
        end
    end

    // Rotation first, then a press action overrides it (a wrap in the same cycle is dropped).
    always_comb begin
        state_nxt = state;
        leds_nxt  = leds;
        tick_nxt  = '0;

        if (state != MODE_STATIC) begin
            tick_nxt = wrap_c ? '0 : tick + TICK_W'(1);
            if (wrap_c) begin
                if (state == MODE_ROT_L) leds_nxt = {leds[WIDTH-2:0], leds[WIDTH-1]};
                else                     leds_nxt = {leds[0], leds[WIDTH-1:1]};
            end
        end

        case (act_c)
            ACT_UP: begin
                leds_nxt  = '1;
                state_nxt = MODE_STATIC;
                tick_nxt  = '0;
            end
            ACT_DWN: begin
                leds_nxt  = '0;
                state_nxt = MODE_STATIC;
                tick_nxt  = '0;
            end
            ACT_LFT: begin
                state_nxt = MODE_ROT_L;
                tick_nxt  = '0;
                leds_nxt  = (leds == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : leds;
            end
            ACT_RT: begin
                state_nxt = MODE_ROT_R;
                tick_nxt  = '0;
                leds_nxt  = (leds == '0) ? {1'b1, {(WIDTH-1){1'b0}}} : leds;
            end
            ACT_CTR: begin
                leds_nxt  = switches;
                state_nxt = MODE_STATIC;
                tick_nxt  = '0;
            end
            default: ;
        endcase
    end

    assign mode = state;

endmodule

// File: tb/tb_led_ctrl_fsm.sv
// Scoreboard bench for led_ctrl_fsm (WIDTH=8, DEBOUNCE_CYCLES=4, SHIFT_DIV=3):
// stimulus queues {edge, leds, mode} expectations; a monitor pops one per output change.
module tb_led_ctrl_fsm;
    import led_ctrl_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned DB = 4;
    localparam int unsigned SD = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] switches = '0;
    logic         btn_up = 1'b0, btn_dwn = 1'b0, btn_lft = 1'b0, btn_rt = 1'b0, btn_ctr = 1'b0;
    logic [W-1:0] leds;
    logic [1:0]   mode;
    logic [4:0]   btn_db;

    led_ctrl_fsm #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .SHIFT_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches),
        .btn_up(btn_up), .btn_dwn(btn_dwn), .btn_lft(btn_lft), .btn_rt(btn_rt), .btn_ctr(btn_ctr),
        .leds(leds), .mode(mode), .btn_db(btn_db)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [7:0] l;
        logic [1:0] m;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    bit         mon_en = 1'b0;
    logic [7:0] pl = '0;
    logic [1:0] pm = '0;

    task automatic push(input int c, input logic [7:0] l, input logic [1:0] m);
        exp_t e;
        e.c = c; e.l = l; e.m = m;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every change of {leds,mode} must match the next queued expectation, edge included.
    always @(negedge clk) begin
        if (mon_en && ({leds, mode} !== {pl, pm})) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: edge=%0d leds=%h mode=%0d", cyc, leds, mode);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.c != cyc || e.l !== leds || e.m !== mode) begin
                    errors++;
                    $display("FAIL output_change: got edge=%0d leds=%h mode=%0d expected edge=%0d leds=%h mode=%0d",
                             cyc, leds, mode, e.c, e.l, e.m);
                end
            end
            pl = leds;
            pm = mode;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, e0, r, r2, l;
        bit seen;

        // Reset values
        step(2);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        check("reset_btn_db", 32'(btn_db), 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(3);

        // up held 20 cycles: one update 6 edges after first sample, nothing more
        n = cyc; btn_up = 1'b1; push(n + 7, 8'hFF, 2'd0);
        step(20); btn_up = 1'b0; step(10);

        // 3-cycle glitch on dwn never reaches btn_db
        seen = 1'b0;
        btn_dwn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) btn_dwn = 1'b0;
            @(negedge clk);
            if (btn_db[BTN_DWN]) seen = 1'b1;
        end
        check("glitch_db", 32'(seen), 32'h0);

        n = cyc; btn_dwn = 1'b1; push(n + 7, 8'h00, 2'd0);
        step(10); btn_dwn = 1'b0; step(10);

        // lft from all-off: 01 then a full left cycle wrapping 80 -> 01
        n = cyc; btn_lft = 1'b1; e0 = n + 7;
        push(e0, 8'h01, 2'd1);
        for (int j = 1; j <= 8; j++) begin
            logic [7:0] v;
            v = 8'h01 << (j % 8);
            push(e0 + 3 * j, v, 2'd1);
        end
        step(5); btn_lft = 1'b0;
        wait_to(e0 + 19);
        btn_dwn = 1'b1; push(e0 + 26, 8'h00, 2'd0);
        step(5); btn_dwn = 1'b0; step(12);

        // rt from all-off, then ctr loads switches mid-rotation
        switches = 8'hA5;
        n = cyc; btn_rt = 1'b1; r = n + 7;
        push(r, 8'h80, 2'd2); push(r + 3, 8'h40, 2'd2); push(r + 6, 8'h20, 2'd2);
        step(5); btn_rt = 1'b0;
        wait_to(r);
        btn_ctr = 1'b1; push(r + 7, 8'hA5, 2'd0);
        step(5); btn_ctr = 1'b0; step(12);

        // rt keeps A5, rotates right; up lands on a wrap edge and wins
        n = cyc; btn_rt = 1'b1; r2 = n + 7;
        push(r2, 8'hA5, 2'd2); push(r2 + 3, 8'hD2, 2'd2); push(r2 + 6, 8'h69, 2'd2);
        step(5); btn_rt = 1'b0;
        wait_to(r2 + 2);
        btn_up = 1'b1; push(r2 + 9, 8'hFF, 2'd0);
        step(5); btn_up = 1'b0; step(12);

        // up and ctr on the same edge: up wins, switch load discarded
        n = cyc; btn_dwn = 1'b1; push(n + 7, 8'h00, 2'd0);
        step(5); btn_dwn = 1'b0; step(12);
        switches = 8'h3C;
        n = cyc; btn_up = 1'b1; btn_ctr = 1'b1; push(n + 7, 8'hFF, 2'd0);
        step(5); btn_up = 1'b0; btn_ctr = 1'b0; step(12);

        // 81 in ROT_L, re-press lft to restart the phase, then async reset mid-rotation
        switches = 8'h81;
        n = cyc; btn_ctr = 1'b1; push(n + 7, 8'h81, 2'd0);
        step(5); btn_ctr = 1'b0; step(12);
        n = cyc; btn_lft = 1'b1; l = n + 7;
        push(l, 8'h81, 2'd1); push(l + 3, 8'h03, 2'd1); push(l + 6, 8'h06, 2'd1);
        push(l + 9, 8'h0C, 2'd1); push(l + 12, 8'h18, 2'd1);
        step(5); btn_lft = 1'b0;
        wait_to(n + 13);
        btn_lft = 1'b1;
        push(l + 16, 8'h30, 2'd1);
        wait_to(l + 17);
        btn_lft = 1'b0;
        @(posedge clk);
        push(l + 18, 8'h00, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(leds), 32'h0);
        check("async_reset_mode", 32'(mode), 32'h0);
        check("async_reset_btn_db", 32'(btn_db), 32'h0);
        step(3);
        rst_n = 1'b1;
        step(15);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
